matrix_frame_scheduler: RTL and testbench

MATRIX_FRAME_SCHEDULER -- requirements
Module: matrix_frame_scheduler

---
 rtl/matrix_frame_scheduler.sv | 149 ++++++++++++++
 tb/tb_matrix_frame_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_scheduler.sv
`timescale 1ns/1ps
// Matrix frame scheduler: reads a tiled frame buffer panel by panel and streams
// each pixel, tagged with its panel index and first/last flags, to a shared transmitter.
module matrix_frame_scheduler #(
  parameter int PANELS_X = 4,
  parameter int PANELS_Y = 2,
  parameter int PANEL_W  = 16,
  parameter int PANEL_H  = 8,
  localparam int FB_W = PANELS_X * PANEL_W,
  localparam int AW   = (FB_W * PANELS_Y * PANEL_H > 1) ? $clog2(FB_W * PANELS_Y * PANEL_H) : 1,
  localparam int PW   = (PANELS_X * PANELS_Y > 1) ? $clog2(PANELS_X * PANELS_Y) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          frame_ready,
  output logic          buf_rd_en,
  output logic [AW-1:0] buf_rd_addr,
  input  logic [23:0]   buf_rd_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [23:0]   tx_data,
  output logic [PW-1:0] tx_panel,
  output logic          tx_first,
  output logic          tx_last,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_dropped
);

  localparam int XW  = (PANEL_W  > 1) ? $clog2(PANEL_W)  : 1;
  localparam int YW  = (PANEL_H  > 1) ? $clog2(PANEL_H)  : 1;
  localparam int PXW = (PANELS_X > 1) ? $clog2(PANELS_X) : 1;
  localparam int PYW = (PANELS_Y > 1) ? $clog2(PANELS_Y) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_t;

  state_t         state, state_nxt;
  logic           pending, pending_nxt;
  logic           start, hs, drop;
  logic           x_max, y_max, px_max, py_max, frame_last;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;

  assign x_max      = (x  == XW'(PANEL_W - 1));
  assign y_max      = (y  == YW'(PANEL_H - 1));
  assign px_max     = (px == PXW'(PANELS_X - 1));
  assign py_max     = (py == PYW'(PANELS_Y - 1));
  assign frame_last = x_max & y_max & px_max & py_max;
  assign hs         = (state == SEND) & tx_ready;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE:  if (enable && (frame_ready || pending)) begin
               state_nxt = ISSUE;
               start     = 1'b1;
             end
      ISSUE: state_nxt = WAIT;
      WAIT:  state_nxt = SEND;
      SEND:  if (tx_ready) state_nxt = frame_last ? DONE : ISSUE;
      DONE:  if (enable && (frame_ready || pending)) begin
               state_nxt = ISSUE;
               start     = 1'b1;
             end else begin
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // A start consumes the request; a second request arriving while one is
  // already queued behind a busy readout is lost and reported.
  always_comb begin
    drop        = frame_ready & pending & (state != IDLE);
    pending_nxt = start ? 1'b0 : (pending | frame_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      state         <= state_nxt;
      pending       <= pending_nxt;
      frame_dropped <= drop;
    end
  end

  // Scan counters: x fastest, then y, then px, then py; the final carry wraps
  // everything back to zero at the end of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x  <= '0;
      y  <= '0;
      px <= '0;
      py <= '0;
    end else if (start) begin
      x  <= '0;
      y  <= '0;
      px <= '0;
      py <= '0;
    end else if (hs) begin
      if (!x_max) begin
        x <= x + XW'(1);
      end else begin
        x <= '0;
        if (!y_max) begin
          y <= y + YW'(1);
        end else begin
          y <= '0;
          if (!px_max) begin
            px <= px + PXW'(1);
          end else begin
            px <= '0;
            py <= py_max ? '0 : py + PYW'(1);
          end
        end
      end
    end
  end

  // Read data returns during WAIT; capture it with its tags for SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= '0;
      tx_panel <= '0;
      tx_first <= 1'b0;
      tx_last  <= 1'b0;
    end else if (state == WAIT) begin
      tx_data  <= buf_rd_data;
      tx_panel <= PW'(py) * PW'(PANELS_X) + PW'(px);
      tx_first <= (x == '0) & (y == '0);
      tx_last  <= x_max & y_max;
    end
  end

  assign buf_rd_addr = (AW'(py) * AW'(PANEL_H) + AW'(y)) * AW'(FB_W)
                     + AW'(px) * AW'(PANEL_W) + AW'(x);
  assign buf_rd_en   = (state == ISSUE);
  assign tx_valid    = (state == SEND);
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
`timescale 1ns/1ps
// Bench for matrix_frame_scheduler: a 2x1 panel instance under random stimulus
// and a default-parameter instance, both checked against a scan-order model.
module tb_matrix_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- small instance (2x1 panels of 4x2) ----------------
  logic        rst, s_enable, s_frame_ready, s_rd_en, s_tx_valid, s_tx_ready;
  logic [3:0]  s_rd_addr;
  logic [23:0] s_rd_data, s_tx_data;
  logic [0:0]  s_tx_panel;
  logic        s_first, s_last, s_busy, s_done, s_drop;

  matrix_frame_scheduler #(.PANELS_X(2), .PANELS_Y(1), .PANEL_W(4), .PANEL_H(2)) u_small (
    .clk(clk), .rst(rst), .enable(s_enable), .frame_ready(s_frame_ready),
    .buf_rd_en(s_rd_en), .buf_rd_addr(s_rd_addr), .buf_rd_data(s_rd_data),
    .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .tx_data(s_tx_data),
    .tx_panel(s_tx_panel), .tx_first(s_first), .tx_last(s_last),
    .busy(s_busy), .frame_done(s_done), .frame_dropped(s_drop));

  // ---------------- default instance (4x2 panels of 16x8) ----------------
  logic        d_rst, d_enable, d_frame_ready, d_rd_en, d_tx_valid, d_tx_ready;
  logic [9:0]  d_rd_addr;
  logic [23:0] d_rd_data, d_tx_data;
  logic [2:0]  d_tx_panel;
  logic        d_first, d_last, d_busy, d_done, d_drop;

  matrix_frame_scheduler u_dflt (
    .clk(clk), .rst(d_rst), .enable(d_enable), .frame_ready(d_frame_ready),
    .buf_rd_en(d_rd_en), .buf_rd_addr(d_rd_addr), .buf_rd_data(d_rd_data),
    .tx_valid(d_tx_valid), .tx_ready(d_tx_ready), .tx_data(d_tx_data),
    .tx_panel(d_tx_panel), .tx_first(d_first), .tx_last(d_last),
    .busy(d_busy), .frame_done(d_done), .frame_dropped(d_drop));

  // ---------------- reference model ----------------
  function automatic logic [23:0] pix(input int a);
    logic [31:0] t;
    t = (a * 32'h0001_0203) ^ 32'h005A_5A5A;
    return t[23:0];
  endfunction

  // Address of the idx-th pixel in scan order, straight from the tiling rules.
  function automatic int exp_addr(input int npx, input int w, input int h, input int idx);
    int p, r, px, py, x, y;
    p  = idx / (w * h);
    r  = idx % (w * h);
    px = p % npx;
    py = p / npx;
    y  = r / w;
    x  = r % w;
    return (py * h + y) * (npx * w) + px * w + x;
  endfunction

  function automatic int exp_panel(input int w, input int h, input int idx);
    return idx / (w * h);
  endfunction

  function automatic bit exp_first(input int w, input int h, input int idx);
    return (idx % (w * h)) == 0;
  endfunction

  function automatic bit exp_last(input int w, input int h, input int idx);
    return (idx % (w * h)) == (w * h - 1);
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Frame buffer: data valid exactly one cycle after the read strobe.
  always @(posedge clk) begin
    s_rd_data <= s_rd_en ? pix(int'(s_rd_addr)) : 24'hBAD0BA;
    d_rd_data <= d_rd_en ? pix(int'(d_rd_addr)) : 24'hBAD0BA;
  end

  bit rand_ready = 0;
  always @(posedge clk) begin
    #1;
    s_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- small-instance compare process ----------------
  int s_idx = 0, s_iidx = 0, s_frames = 0, s_drops = 0, start_cyc = 0, done_cyc = 0;
  bit prev_stall = 0;
  logic [23:0] prev_data;
  logic [2:0]  prev_meta;

  always @(negedge clk) begin
    if (rst) begin
      s_idx = 0;
      s_iidx = 0;
      prev_stall = 0;
    end else begin
      if (s_rd_en) begin
        if (s_iidx == 0) start_cyc = cyc;
        chk("s_rd_addr", s_rd_addr, exp_addr(2, 4, 2, s_iidx));
        s_iidx++;
      end
      if (prev_stall) begin
        chk("stall_valid", s_tx_valid, 1);
        chk("stall_data", s_tx_data, prev_data);
        chk("stall_tags", {s_tx_panel, s_first, s_last}, prev_meta);
      end
      if (s_tx_valid && s_tx_ready) begin
        chk("s_tx_data", s_tx_data, pix(exp_addr(2, 4, 2, s_idx)));
        chk("s_tx_panel", s_tx_panel, exp_panel(4, 2, s_idx));
        chk("s_tx_first", s_first, exp_first(4, 2, s_idx));
        chk("s_tx_last", s_last, exp_last(4, 2, s_idx));
        s_idx++;
      end
      prev_stall = s_tx_valid && !s_tx_ready;
      prev_data  = s_tx_data;
      prev_meta  = {s_tx_panel, s_first, s_last};
      if (s_done) begin
        chk("frame_len", s_idx, 16);
        s_idx = 0;
        s_iidx = 0;
        s_frames++;
        done_cyc = cyc;
      end
      if (s_drop) s_drops++;
    end
  end

  // ---------------- default-instance compare process ----------------
  int d_idx = 0, d_iidx = 0, d_firsts = 0, d_lasts = 0, d_last_addr = -1, d_frames = 0;

  always @(negedge clk) begin
    if (!d_rst) begin
      if (d_rd_en) begin
        d_last_addr = int'(d_rd_addr);
        chk("d_rd_addr", d_rd_addr, exp_addr(4, 16, 8, d_iidx));
        d_iidx++;
      end
      if (d_tx_valid && d_tx_ready) begin
        chk("d_tx_data", d_tx_data, pix(exp_addr(4, 16, 8, d_idx)));
        chk("d_tx_panel", d_tx_panel, exp_panel(16, 8, d_idx));
        if (d_first) begin
          chk("d_panel_order", d_tx_panel, d_firsts);
          d_firsts++;
        end
        if (d_last) d_lasts++;
        d_idx++;
      end
      if (d_done) d_frames++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_s();
    @(posedge clk); #1 s_frame_ready = 1'b1;
    @(posedge clk); #1 s_frame_ready = 1'b0;
  endtask

  task automatic wait_s_frames(input int target, input int bound, input string name);
    int c;
    c = 0;
    while (s_frames < target && c < bound) begin
      @(posedge clk);
      c++;
    end
    if (s_frames < target) chk({name, "_timeout"}, s_frames, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, dr0, c;
    bit bad;
    rst = 1'b1; d_rst = 1'b1;
    s_enable = 1'b0; s_frame_ready = 1'b0; s_tx_ready = 1'b1;
    d_enable = 1'b0; d_frame_ready = 1'b0; d_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", s_rd_en, 0);
    chk("rst_rd_addr", s_rd_addr, 0);
    chk("rst_tx_valid", s_tx_valid, 0);
    chk("rst_tx_data", s_tx_data, 0);
    chk("rst_busy", {s_busy, s_done, s_drop, s_first, s_last}, 0);
    chk("rst_d_outputs", {d_rd_en, d_rd_addr, d_tx_valid, d_tx_data, d_busy}, 0);

    // Literal pins on the scan-order model.
    chk("model_idx4", exp_addr(2, 4, 2, 4), 8);
    chk("model_idx8", exp_addr(2, 4, 2, 8), 4);
    chk("model_idx15", exp_addr(2, 4, 2, 15), 15);
    chk("model_dflt128", exp_addr(4, 16, 8, 128), 16);
    chk("model_dflt1023", exp_addr(4, 16, 8, 1023), 1023);

    @(posedge clk); #1 rst = 1'b0; d_rst = 1'b0;

    // Default parameters: one full frame.
    d_enable = 1'b1;
    @(posedge clk); #1 d_frame_ready = 1'b1;
    @(posedge clk); #1 d_frame_ready = 1'b0;
    c = 0;
    while (d_frames < 1 && c < 4000) begin @(posedge clk); c++; end
    chk("d_frame_count", d_frames, 1);
    chk("d_pixels", d_idx, 1024);
    chk("d_first_count", d_firsts, 8);
    chk("d_last_count", d_lasts, 8);
    chk("d_last_addr", d_last_addr, 1023);
    chk("d_no_drop", d_drop, 0);

    // Single frame at full rate: 16 pixels, done 48 cycles after start.
    s_enable = 1'b1;
    pulse_s();
    wait_s_frames(1, 200, "frame1");
    chk("done_latency", done_cyc - start_cyc, 48);

    // Random back-pressure.
    rand_ready = 1;
    pulse_s();
    wait_s_frames(2, 1000, "frame2");
    rand_ready = 0;
    repeat (3) @(posedge clk);

    // Two extra requests while busy: one queued, one dropped.
    f0 = s_frames; dr0 = s_drops;
    pulse_s();
    repeat (10) @(posedge clk);
    pulse_s();
    repeat (10) @(posedge clk);
    pulse_s();
    wait_s_frames(f0 + 2, 400, "queued");
    repeat (20) @(posedge clk);
    chk("queued_frames", s_frames - f0, 2);
    chk("dropped_pulses", s_drops - dr0, 1);
    chk("idle_after_queue", s_busy, 0);

    // Request while disabled waits for enable.
    s_enable = 1'b0;
    pulse_s();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_busy || s_rd_en) bad = 1;
    end
    chk("held_while_disabled", bad, 0);
    @(posedge clk); #1 s_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("start_after_enable", s_rd_en, 1);
    wait_s_frames(f0 + 3, 200, "enabled");

    // Reset mid-frame.
    f0 = s_frames;
    pulse_s();
    c = 0;
    while (s_idx < 5 && c < 200) begin @(negedge clk); c++; end
    chk("reached_pixel5", s_idx, 5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", s_tx_valid, 0);
    chk("mid_rst_tx_data", s_tx_data, 0);
    chk("mid_rst_addr", s_rd_addr, 0);
    chk("mid_rst_flags", {s_busy, s_rd_en, s_first, s_last, s_tx_panel}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("no_done_after_rst", s_frames, f0);
    chk("idle_after_rst", s_busy, 0);
    pulse_s();
    wait_s_frames(f0 + 1, 200, "after_rst");
    chk("frames_after_rst", s_frames, f0 + 1);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
